branch_predictor: RTL and testbench

//  Direct-mapped branch target buffer with per-entry saturating direction counters for the 5-stage MIPS pipeline.
//  IF-stage lookup returns a predicted next PC in the same cycle.
//  ID-stage branch resolution updates the table and flags mispredictions.
//  The block replaces the fixed predict-not-taken policy, in which every taken branch/jump costs one IF/ID flush.

---
 rtl/bp_pkg.sv | 27 ++
 rtl/sat_counter.sv | 20 ++
 rtl/branch_predictor.sv | 114 +++++++++++
 tb/tb_branch_predictor.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch target buffer.
// Entry fields are sized for the widest configuration.
package bp_pkg;

    localparam int BP_PC_W  = 32;
    localparam int BP_CTR_W = 2;

    localparam logic [BP_CTR_W-1:0] CTR_WEAK_T =
        {1'b1, {(BP_CTR_W-1){1'b0}}};
    localparam logic [BP_CTR_W-1:0] CTR_MAX = '1;

    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int tag_w(input int pc_w, input int entries);
        return pc_w - idx_w(entries) - 2;
    endfunction

    typedef struct packed {
        logic                valid;
        logic [BP_PC_W-1:0]  tag;
        logic [BP_PC_W-1:0]  target;
        logic [BP_CTR_W-1:0] ctr;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter step; holds at zero and at all-ones.
module sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] cur,
    input  logic             inc,
    input  logic             dec,
    output logic [CTR_W-1:0] nxt
);

    always_comb begin
        nxt = cur;
        unique case (1'b1)
            inc: if (cur != '1) nxt = cur + CTR_W'(1);
            dec: if (cur != '0) nxt = cur - CTR_W'(1);
            default: nxt = cur;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters.
// IF lookup is combinational; ID resolution updates at the clock edge.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_W    = BP_PC_W,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = BP_CTR_W,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              id_valid,
    input  logic              id_stall,
    input  logic [PC_W-1:0]   id_pc,
    input  logic              id_is_branch,
    input  logic              id_taken,
    input  logic [PC_W-1:0]   id_target,
    input  logic              id_pred_taken,
    input  logic [PC_W-1:0]   id_pred_target,
    output logic              mispredict,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int IDX_W = idx_w(ENTRIES);
    localparam int TAG_W = tag_w(PC_W, ENTRIES);

    btb_entry_t btb_q [ENTRIES];

    logic [IDX_W-1:0] if_idx, id_idx;
    logic [TAG_W-1:0] if_tag, id_tag;
    btb_entry_t       if_ent, id_ent, upd_ent;
    logic             if_hit, id_hit;
    logic             upd, upd_we, alias_hit, br_miss;
    logic [CTR_W-1:0] ctr_nxt;
    logic [PC_W-1:0]  pc_plus4;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[PC_W-1:IDX_W+2];
    assign id_idx = id_pc[IDX_W+1:2];
    assign id_tag = id_pc[PC_W-1:IDX_W+2];

    assign if_ent = btb_q[if_idx];
    assign id_ent = btb_q[id_idx];

    assign if_hit = if_ent.valid && (if_ent.tag == BP_PC_W'(if_tag));
    assign id_hit = id_ent.valid && (id_ent.tag == BP_PC_W'(id_tag));

    assign pred_taken  = !reset && if_hit && if_ent.ctr[CTR_W-1];
    assign pred_target = PC_W'(if_ent.target);

    assign upd = !reset && id_valid && !id_stall && id_is_branch;

    // A non-branch that was fetched under a taken prediction is an alias.
    assign alias_hit = !reset && id_valid && !id_stall
                     && !id_is_branch && id_pred_taken;

    assign br_miss = upd && ((id_taken != id_pred_taken)
                   || (id_taken && id_pred_taken
                       && (id_target != id_pred_target)));

    assign mispredict  = br_miss || alias_hit;
    assign pc_plus4    = id_pc + PC_W'(4);
    assign redirect_pc = (id_is_branch && id_taken) ? id_target : pc_plus4;

    sat_counter #(.CTR_W(CTR_W)) u_ctr (
        .cur (CTR_W'(id_ent.ctr)),
        .inc (id_taken),
        .dec (!id_taken),
        .nxt (ctr_nxt)
    );

    always_comb begin
        upd_ent = id_ent;
        unique case (1'b1)
            id_hit: begin
                upd_ent.ctr = BP_CTR_W'(ctr_nxt);
                if (id_taken) upd_ent.target = BP_PC_W'(id_target);
            end
            (!id_hit && id_taken): begin
                upd_ent.valid  = 1'b1;
                upd_ent.tag    = BP_PC_W'(id_tag);
                upd_ent.target = BP_PC_W'(id_target);
                upd_ent.ctr    = CTR_WEAK_T;
            end
            default: upd_ent = id_ent;
        endcase
    end

    assign upd_we = upd && (id_hit || id_taken);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (upd_we) btb_q[id_idx] <= upd_ent;
            if (upd && branch_cnt != '1)
                branch_cnt <= branch_cnt + STAT_W'(1);
            if (mispredict && mispred_cnt != '1)
                mispred_cnt <= mispred_cnt + STAT_W'(1);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{if_pc[1:0], if_ent.ctr};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: vector table with a
// scoreboard queue, plus saturation and mid-run reset sequences.
module tb_branch_predictor;

    localparam logic [31:0] B   = 32'h0040_0010;
    localparam logic [31:0] T   = 32'h0040_0040;
    localparam logic [31:0] T2  = 32'h0040_0080;
    localparam logic [31:0] P14 = 32'h0040_0014;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc, id_pc, id_target, id_pred_target;
    logic        id_valid, id_stall, id_is_branch, id_taken, id_pred_taken;
    logic        pred_taken, mispredict;
    logic [31:0] pred_target, redirect_pc;
    logic [15:0] branch_cnt, mispred_cnt;

    branch_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .id_valid       (id_valid),
        .id_stall       (id_stall),
        .id_pc          (id_pc),
        .id_is_branch   (id_is_branch),
        .id_taken       (id_taken),
        .id_target      (id_target),
        .id_pred_taken  (id_pred_taken),
        .id_pred_target (id_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] if_pc;
        logic        v, st, br, tk;
        logic [31:0] pc, tgt;
        logic        pt;
        logic [31:0] ptg;
        logic        e_pt;
        logic [31:0] e_ptg;
        logic        e_mp;
        logic [31:0] e_rd;
        logic [15:0] e_bc, e_mc;
    } vec_t;

    typedef struct {
        int          id;
        logic        e_pt;
        logic [31:0] e_ptg;
        logic        e_mp;
        logic [31:0] e_rd;
        logic [15:0] e_bc, e_mc;
    } exp_t;

    vec_t vecs [24];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(
        input logic [31:0] ipc, input logic v, st, br, tk,
        input logic [31:0] pc, tgt, input logic pt,
        input logic [31:0] ptg, input logic e_pt,
        input logic [31:0] e_ptg, input logic e_mp,
        input logic [31:0] e_rd, input logic [15:0] e_bc, e_mc);
        vec_t r;
        r.if_pc = ipc; r.v = v; r.st = st; r.br = br; r.tk = tk;
        r.pc = pc; r.tgt = tgt; r.pt = pt; r.ptg = ptg;
        r.e_pt = e_pt; r.e_ptg = e_ptg; r.e_mp = e_mp;
        r.e_rd = e_rd; r.e_bc = e_bc; r.e_mc = e_mc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        if_pc          = t.if_pc;
        id_valid       = t.v;
        id_stall       = t.st;
        id_is_branch   = t.br;
        id_taken       = t.tk;
        id_pc          = t.pc;
        id_target      = t.tgt;
        id_pred_taken  = t.pt;
        id_pred_target = t.ptg;
    endtask

    task automatic compare(input exp_t e);
        string s;
        s = $sformatf("v%0d", e.id);
        chk({s, ".pred_taken"}, 32'(pred_taken), 32'(e.e_pt));
        if (e.e_pt) chk({s, ".pred_target"}, pred_target, e.e_ptg);
        chk({s, ".mispredict"}, 32'(mispredict), 32'(e.e_mp));
        if (e.e_mp) chk({s, ".redirect_pc"}, redirect_pc, e.e_rd);
        chk({s, ".branch_cnt"}, 32'(branch_cnt), 32'(e.e_bc));
        chk({s, ".mispred_cnt"}, 32'(mispred_cnt), 32'(e.e_mc));
    endtask

    task automatic apply(input int id, input vec_t t);
        exp_t e;
        @(negedge clk);
        drive(t);
        e.id = id; e.e_pt = t.e_pt; e.e_ptg = t.e_ptg;
        e.e_mp = t.e_mp; e.e_rd = t.e_rd;
        e.e_bc = t.e_bc; e.e_mc = t.e_mc;
        sb.push_back(e);
        #1;
        compare(sb.pop_front());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(32'h0040_0000,0,0,0,0,0,0,0,0, 0,0, 0,0, 0,0);
        vecs[1]  = mk(B,1,0,1,1,B,T,0,0,   0,0,  1,T,   0,0);
        vecs[2]  = mk(B,0,0,0,0,0,0,0,0,   1,T,  0,0,   1,1);
        vecs[3]  = mk(B,1,0,1,0,B,T,1,T,   1,T,  1,P14, 1,1);
        vecs[4]  = mk(B,0,0,0,0,0,0,0,0,   0,0,  0,0,   2,2);
        vecs[5]  = mk(B,1,0,1,0,B,T,0,0,   0,0,  0,0,   2,2);
        vecs[6]  = mk(B,0,0,0,0,0,0,0,0,   0,0,  0,0,   3,2);
        vecs[7]  = mk(B,1,0,1,1,B,T,0,0,   0,0,  1,T,   3,2);
        vecs[8]  = mk(B,0,0,0,0,0,0,0,0,   0,0,  0,0,   4,3);
        vecs[9]  = mk(B,1,0,0,0,32'h0040_0050,0,1,T,
                      0,0, 1,32'h0040_0054, 4,3);
        vecs[10] = mk(32'h0040_0050,0,0,0,0,0,0,0,0,
                      0,0, 0,0, 4,4);
        vecs[11] = mk(B,1,1,1,1,B,T,0,0,   0,0,  0,0,   4,4);
        vecs[12] = mk(B,1,0,1,1,B,T,0,0,   0,0,  1,T,   4,4);
        vecs[13] = mk(B,0,0,0,0,0,0,0,0,   1,T,  0,0,   5,5);
        vecs[14] = mk(B,1,0,1,1,B,T2,1,T,  1,T,  1,T2,  5,5);
        vecs[15] = mk(B,0,0,0,0,0,0,0,0,   1,T2, 0,0,   6,6);
        vecs[16] = mk(B,1,0,1,1,B,T2,1,T2, 1,T2, 0,0,   6,6);
        vecs[17] = mk(B,1,0,1,0,B,T2,1,T2, 1,T2, 1,P14, 7,6);
        vecs[18] = mk(B,0,0,0,0,0,0,0,0,   1,T2, 0,0,   8,7);
        vecs[19] = mk(B,0,0,1,1,B,T,0,0,   1,T2, 0,0,   8,7);
        vecs[20] = mk(B,1,0,1,0,32'h0040_0100,T,0,0,
                      1,T2, 0,0, 8,7);
        vecs[21] = mk(32'h0040_0100,0,0,0,0,0,0,0,0,
                      0,0, 0,0, 9,7);
        vecs[22] = mk(B,1,0,1,0,32'hFFFF_FFFC,0,1,T,
                      1,T2, 1,32'h0000_0000, 9,7);
        vecs[23] = mk(B,0,0,0,0,0,0,0,0,   1,T2, 0,0,   10,8);

        reset = 1'b1;
        drive(vecs[0]);
        repeat (2) @(negedge clk);
        #1;
        chk("in_reset.branch_cnt", 32'(branch_cnt), 32'd0);
        chk("in_reset.pred_taken", 32'(pred_taken), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 24; i++) apply(i, vecs[i]);

        // Miss, not-taken branch predicted taken: both stats count each cycle.
        @(negedge clk);
        drive(mk(B,1,0,1,0,32'h0040_0200,0,1,T, 0,0,0,0,0,0));
        repeat (65540) @(negedge clk);
        #1;
        chk("sat.mispredict", 32'(mispredict), 32'd1);
        chk("sat.branch_cnt", 32'(branch_cnt), 32'h0000_FFFF);
        chk("sat.mispred_cnt", 32'(mispred_cnt), 32'h0000_FFFF);
        @(negedge clk);
        #1;
        chk("sat_hold.branch_cnt", 32'(branch_cnt), 32'h0000_FFFF);
        chk("sat_hold.mispred_cnt", 32'(mispred_cnt), 32'h0000_FFFF);
        chk("sat_hold.pred_taken_B", 32'(pred_taken), 32'd1);

        reset = 1'b1;
        #1;
        chk("rst.branch_cnt", 32'(branch_cnt), 32'd0);
        chk("rst.mispred_cnt", 32'(mispred_cnt), 32'd0);
        chk("rst.pred_taken", 32'(pred_taken), 32'd0);
        chk("rst.mispredict", 32'(mispredict), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(vecs[0]);
        if_pc = B;
        @(negedge clk);
        #1;
        chk("post_rst.pred_taken", 32'(pred_taken), 32'd0);
        chk("post_rst.branch_cnt", 32'(branch_cnt), 32'd0);
        chk("post_rst.mispred_cnt", 32'(mispred_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
